// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: configurable data/parity/stop format,
// error flags and a valid/ack output holding register.
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF      = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] T_LAST      = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_BIT     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_reg, state_next;
    logic [TW-1:0]        tcnt_reg, tcnt_next;
    logic [BW-1:0]        bcnt_reg, bcnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 perr_reg, perr_next;
    logic                 ferr_reg, ferr_next;
    logic                 done;
    logic                 rx_meta, rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            tcnt_reg  <= '0;
            bcnt_reg  <= '0;
            shift_reg <= '0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            bcnt_reg  <= bcnt_next;
            shift_reg <= shift_next;
            perr_reg  <= perr_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        bcnt_next  = bcnt_reg;
        shift_next = shift_reg;
        perr_next  = perr_reg;
        ferr_next  = ferr_reg;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (baud_tick && !rx_s) begin
                    tcnt_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tcnt_reg == T_HALF) begin
                        if (!rx_s) begin
                            tcnt_next  = '0;
                            bcnt_next  = '0;
                            perr_next  = 1'b0;
                            ferr_next  = 1'b0;
                            state_next = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tcnt_reg == T_LAST) begin
                        tcnt_next  = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bcnt_reg == B_LAST_DATA) begin
                            bcnt_next  = '0;
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bcnt_next = bcnt_reg + 1'b1;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    if (tcnt_reg == T_LAST) begin
                        tcnt_next  = '0;
                        perr_next  = ^shift_reg ^ rx_s ^ ODD_BIT;
                        state_next = STOP;
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tcnt_reg == T_LAST) begin
                        tcnt_next = '0;
                        ferr_next = ferr_reg | ~rx_s;
                        // Leave mid-stop-bit so an immediately following start edge is seen.
                        if (bcnt_reg == B_LAST_STOP) begin
                            bcnt_next  = '0;
                            done       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            bcnt_next = bcnt_reg + 1'b1;
                        end
                    end else begin
                        tcnt_next = tcnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An ack coinciding with completion consumes the old frame and admits the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rx_ack) begin
                rx_data    <= shift_reg;
                parity_err <= perr_reg;
                frame_err  <= ferr_next;
                rx_valid   <= 1'b1;
                if (rx_valid) begin
                    overrun_err <= 1'b0;
                end
            end else begin
                overrun_err <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three differently configured receivers,
// a vector table, hand-written corner sequences and randomized frames vs. a model.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b0;
    logic [2:0] rx_l = 3'b111;
    logic [2:0] ack_l = 3'b000;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [2:0] valid_l, perr_l, ferr_l, ovr_l, busy_l;
    logic [8:0] dd [3];

    int div = 4;
    int tphase = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int got, off, s22;

    // Per-instance frame format: data bits, parity enable, odd parity, stop bits, sample rate
    int db_c [3] = '{8, 8, 9};
    int pen_c[3] = '{0, 1, 1};
    int odd_c[3] = '{0, 0, 1};
    int ns_c [3] = '{1, 2, 1};
    int sr_c [3] = '{16, 16, 8};

    // Behavioural model of the holding register per instance
    bit         m_valid[3];
    logic [8:0] m_data [3];
    bit         m_pe[3], m_fe[3], m_ov[3];

    typedef struct {
        int         inst;
        logic [8:0] data;
        bit         bad;
        bit [1:0]   sv;
        logic [8:0] ed;
        bit         epe;
        bit         efe;
    } vec_t;
    vec_t tbl[12];

    assign dd[0] = {1'b0, d0};
    assign dd[1] = {1'b0, d1};
    assign dd[2] = d2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        tphase    = (tphase + 1 >= div) ? 0 : tphase + 1;
        baud_tick = (tphase == 0);
    end

    uart_rx_param #(.DATA_BITS(8), .SAMPLE_RATE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_l[0]), .rx_data(d0),
        .rx_valid(valid_l[0]), .rx_ack(ack_l[0]), .parity_err(perr_l[0]), .frame_err(ferr_l[0]),
        .overrun_err(ovr_l[0]), .busy(busy_l[0]));

    uart_rx_param #(.DATA_BITS(8), .SAMPLE_RATE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_l[1]), .rx_data(d1),
        .rx_valid(valid_l[1]), .rx_ack(ack_l[1]), .parity_err(perr_l[1]), .frame_err(ferr_l[1]),
        .overrun_err(ovr_l[1]), .busy(busy_l[1]));

    uart_rx_param #(.DATA_BITS(9), .SAMPLE_RATE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_l[2]), .rx_data(d2),
        .rx_valid(valid_l[2]), .rx_ack(ack_l[2]), .parity_err(perr_l[2]), .frame_err(ferr_l[2]),
        .overrun_err(ovr_l[2]), .busy(busy_l[2]));

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(int i, string tag, logic v, logic [8:0] d, logic pe, logic fe, logic ov);
        $display("inst %0d %s: data=%h valid=%b perr=%b ferr=%b ovr=%b busy=%b",
                 i, tag, dd[i], valid_l[i], perr_l[i], ferr_l[i], ovr_l[i], busy_l[i]);
        chk({tag, "_valid"}, 32'(valid_l[i]), 32'(v));
        chk({tag, "_data"},  32'(dd[i]),      32'(d));
        chk({tag, "_perr"},  32'(perr_l[i]),  32'(pe));
        chk({tag, "_ferr"},  32'(ferr_l[i]),  32'(fe));
        chk({tag, "_ovr"},   32'(ovr_l[i]),   32'(ov));
        chk({tag, "_busy"},  32'(busy_l[i]),  32'(0));
    endtask

    task automatic drive(int i, logic v, int n);
        rx_l[i] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        @(negedge clk);
        while (tphase != 0) @(negedge clk);
    endtask

    function automatic int ones(logic [8:0] d, int n);
        int c = 0;
        for (int k = 0; k < n; k++) c += d[k];
        return c;
    endfunction

    // Sends a whole frame; a low stop bit is held low for 3/4 of its period only.
    task automatic send(int i, logic [8:0] data, bit bad, bit [1:0] sv);
        int   per;
        logic p;
        per = sr_c[i] * div;
        p   = 1'(((ones(data, db_c[i]) + odd_c[i]) % 2)) ^ bad;
        drive(i, 1'b0, per);
        for (int k = 0; k < db_c[i]; k++) drive(i, data[k], per);
        if (pen_c[i] != 0) drive(i, p, per);
        for (int s = 0; s < ns_c[i]; s++) begin
            if (sv[s]) begin
                drive(i, 1'b1, per);
            end else begin
                drive(i, 1'b0, (3 * per) / 4);
                drive(i, 1'b1, per - (3 * per) / 4);
            end
        end
    endtask

    task automatic gap(int i);
        drive(i, 1'b1, sr_c[i] * div);
    endtask

    task automatic pulse_ack(int i);
        ack_l[i] = 1'b1;
        @(negedge clk);
        ack_l[i] = 1'b0;
    endtask

    task automatic model_frame(int i, logic [8:0] data, bit bad, bit [1:0] sv);
        int  pbit;
        bit  pe, fe;
        pbit = ((ones(data, db_c[i]) + odd_c[i]) % 2) ^ int'(bad);
        pe   = (pen_c[i] != 0) && (((ones(data, db_c[i]) + pbit + odd_c[i]) % 2) != 0);
        fe   = 1'b0;
        for (int s = 0; s < ns_c[i]; s++) if (!sv[s]) fe = 1'b1;
        if (!m_valid[i]) begin
            m_valid[i] = 1'b1;
            m_data[i]  = data & 9'((1 << db_c[i]) - 1);
            m_pe[i]    = pe;
            m_fe[i]    = fe;
        end else begin
            m_ov[i] = 1'b1;
        end
    endtask

    task automatic model_ack(int i);
        if (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_pe[i]    = 1'b0;
            m_fe[i]    = 1'b0;
            m_ov[i]    = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        tbl[1]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        tbl[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        tbl[3]  = '{0, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
        tbl[4]  = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b0, 1'b0};
        tbl[5]  = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b1, 1'b0};
        tbl[6]  = '{1, 9'h03C, 1'b0, 2'b01, 9'h03C, 1'b0, 1'b1};
        tbl[7]  = '{1, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
        tbl[8]  = '{1, 9'h080, 1'b1, 2'b00, 9'h080, 1'b1, 1'b1};
        tbl[9]  = '{2, 9'h1AB, 1'b0, 2'b11, 9'h1AB, 1'b0, 1'b0};
        tbl[10] = '{2, 9'h1AB, 1'b1, 2'b11, 9'h1AB, 1'b1, 1'b0};
        tbl[11] = '{2, 9'h001, 1'b0, 2'b10, 9'h001, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_out(i, "reset", 1'b0, 9'h0, 1'b0, 1'b0, 1'b0);

        // Vector table: every frame acked afterwards
        align();
        for (int v = 0; v < 12; v++) begin
            send(tbl[v].inst, tbl[v].data, tbl[v].bad, tbl[v].sv);
            gap(tbl[v].inst);
            check_out(tbl[v].inst, $sformatf("vec%0d", v), 1'b1, tbl[v].ed, tbl[v].epe, tbl[v].efe, 1'b0);
            pulse_ack(tbl[v].inst);
            chk($sformatf("vec%0d_ack_valid", v), 32'(valid_l[tbl[v].inst]), 32'(0));
        end

        // Glitch: start bit only 3 ticks long
        begin
            int saw;
            saw = 0;
            align();
            rx_l[0] = 1'b0;
            repeat (3 * div) begin @(negedge clk); if (busy_l[0]) saw = 1; end
            rx_l[0] = 1'b1;
            repeat (16 * div) begin @(negedge clk); if (busy_l[0]) saw = 1; end
            $display("inst 0 glitch: busy_seen=%0d busy=%b valid=%b", saw, busy_l[0], valid_l[0]);
            chk("glitch_busy_seen", 32'(saw), 32'(1));
            chk("glitch_busy_end", 32'(busy_l[0]), 32'(0));
            chk("glitch_valid", 32'(valid_l[0]), 32'(0));
        end

        // Back-to-back frames without ack: second is dropped, overrun set
        align();
        send(0, 9'h011, 1'b0, 2'b11);
        s22 = cyc;
        got = 0;
        off = 0;
        fork
            send(0, 9'h022, 1'b0, 2'b11);
            begin
                int n;
                n = 0;
                while (!busy_l[0] && n < 4 * 64) begin @(negedge clk); n++; end
                n = 0;
                while (busy_l[0] && n < 20 * 64) begin @(negedge clk); n++; end
                if (!busy_l[0] && n > 0) begin
                    off = cyc - s22;
                    got = 1;
                end
            end
        join
        chk("overrun_completion_seen", 32'(got), 32'(1));
        gap(0);
        check_out(0, "overrun", 1'b1, 9'h011, 1'b0, 1'b0, 1'b1);
        pulse_ack(0);
        chk("overrun_ack_valid", 32'(valid_l[0]), 32'(0));
        chk("overrun_ack_ovr", 32'(ovr_l[0]), 32'(0));

        // Same pair, ack exactly on the completion cycle of the second frame
        align();
        send(0, 9'h011, 1'b0, 2'b11);
        s22 = cyc;
        fork
            send(0, 9'h022, 1'b0, 2'b11);
            begin
                int n;
                n = 0;
                while (cyc != s22 + off - 1 && n < 20 * 64) begin @(negedge clk); n++; end
                pulse_ack(0);
            end
        join
        gap(0);
        check_out(0, "simul_ack", 1'b1, 9'h022, 1'b0, 1'b0, 1'b0);
        pulse_ack(0);

        // Reset during data bit 4
        align();
        drive(0, 1'b0, 64);
        for (int k = 0; k < 4; k++) drive(0, 1'b1, 64);
        drive(0, 1'b0, 32);
        chk("midframe_busy", 32'(busy_l[0]), 32'(1));
        reset   = 1'b1;
        rx_l[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_out(i, "midreset", 1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
        gap(0);
        align();
        send(0, 9'h05A, 1'b0, 2'b11);
        gap(0);
        check_out(0, "after_reset", 1'b1, 9'h05A, 1'b0, 1'b0, 1'b0);
        pulse_ack(0);

        // Tick held high continuously
        div = 1;
        align();
        send(0, 9'h0C3, 1'b0, 2'b11);
        gap(0);
        check_out(0, "tick_cont", 1'b1, 9'h0C3, 1'b0, 1'b0, 1'b0);
        pulse_ack(0);
        div = 4;
        align();

        // Randomized frames against the model
        for (int i = 0; i < 3; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_pe[i] = 1'b0; m_fe[i] = 1'b0; m_ov[i] = 1'b0;
        end
        for (int r = 0; r < 24; r++) begin
            int         i;
            logic [8:0] data;
            bit         bad, do_ack;
            bit [1:0]   sv;
            i      = r % 3;
            data   = 9'($urandom_range(0, 511)) & 9'((1 << db_c[i]) - 1);
            bad    = (pen_c[i] != 0) && ($urandom_range(0, 3) == 0);
            sv     = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            do_ack = ($urandom_range(0, 2) != 0);
            send(i, data, bad, sv);
            gap(i);
            model_frame(i, data, bad, sv);
            check_out(i, $sformatf("rnd%0d", r), m_valid[i], m_data[i], m_pe[i], m_fe[i], m_ov[i]);
            if (do_ack) begin
                pulse_ack(i);
                model_ack(i);
                chk($sformatf("rnd%0d_ack_valid", r), 32'(valid_l[i]), 32'(m_valid[i]));
                chk($sformatf("rnd%0d_ack_ovr", r), 32'(ovr_l[i]), 32'(m_ov[i]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, single-clock UART receiver with oversampled bit timing, configurable frame format (data bits, parity, stop bits), error reporting and a valid/ack output handshake. It sits between the pad-side `rx` line and the byte-consuming logic, and replaces the fixed 8N1 receiver. The oversampling tick comes from the shared baud generator as a clock enable, not as a second clock.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `SAMPLE_RATE`, 16: `baud_tick` pulses per bit period, even, legal 8..32.
- `PARITY_EN`, 0: 1 adds one parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `clk`, input, 1: the only clock; everything is rising-edge.
- `reset`, input, 1: asynchronous, active-high.
- `baud_tick`, input, 1: one-`clk` enable, `SAMPLE_RATE` pulses per bit, synchronous to `clk`.
- `rx`, input, 1: serial line, idle high, asynchronous.
- `rx_data`, output, `DATA_BITS`: received word, LSB first on the line.
- `rx_valid`, output, 1: `rx_data` and the error flags hold an unconsumed frame.
- `rx_ack`, input, 1: consumer takes the frame; only meaningful while `rx_valid`=1.
- `parity_err`, output, 1: parity mismatch for the held frame.
- `frame_err`, output, 1: at least one stop bit sampled low for the held frame.
- `overrun_err`, output, 1: sticky; a completed frame was dropped because `rx_valid` was still set.
- `busy`, output, 1: receiver state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rx_s`. The synchroniser flops reset to 1. All sampling uses `rx_s`.
- Tick counter `tcnt` is $clog2(`SAMPLE_RATE`) bits wide and advances only on `baud_tick`. Bit counter `bcnt` is $clog2(`DATA_BITS`+1) bits wide.
- **IDLE**: on a `baud_tick` with `rx_s`=0, clear `tcnt` and go to START.
- **START**: on the tick where `tcnt`=`SAMPLE_RATE`/2−1 (start-bit centre):
  - `rx_s`=0: clear `tcnt` and `bcnt`, go to DATA.
  - `rx_s`=1 (glitch): return to IDLE. No output changes.
- **DATA**: on the tick where `tcnt`=`SAMPLE_RATE`−1, shift `rx_s` into the MSB of the shift register (right-shift) and increment `bcnt`. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, else to STOP.
- **PARITY**: sample at bit centre. Error = (XOR of data bits XOR sampled bit XOR `PARITY_ODD`) ≠ 0.
- **STOP**: sample each stop bit at its centre; any 0 sets the frame error. On the last stop-bit sample, complete the frame and go straight to IDLE (mid-stop-bit), so a start edge that immediately follows is caught.
- **Frame completion**:
  - `rx_valid`=0, or `rx_ack`=1 in the same cycle: load `rx_data`, `parity_err` and `frame_err`; set `rx_valid`=1.
  - `rx_valid`=1 and `rx_ack`=0: discard the new frame; held data and flags are unchanged; set `overrun_err`.
- `rx_ack` with `rx_valid`=1 and no simultaneous completion clears `rx_valid`, `parity_err`, `frame_err` and `overrun_err`. `rx_ack` while `rx_valid`=0 is ignored.
- A frame with a frame or parity error is still delivered, with its flag set.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `busy`=0. State is IDLE and all counters are 0.
- Reset mid-frame aborts the frame immediately; nothing is delivered.
- Start detect: `busy` rises 1 `clk` after the first `baud_tick` that sees `rx_s`=0. Input latency is 2 `clk` of synchroniser plus up to 1 tick period.
- `rx_valid` and the flags update on the `clk` edge following the `baud_tick` that samples the last stop-bit centre. `busy` falls on that same edge.
- `rx_valid` is a level signal; it stays high until an acked cycle.
- `baud_tick` held high continuously is legal (tick = `clk`).
- `rx_ack` is synchronous and needs no minimum width.

## Test plan
- **8N1 frame**: `SAMPLE_RATE`=16, `baud_tick` every 4 `clk`, send 0xA5 → `rx_data`=0xA5, `rx_valid`=1, all error flags 0. Ack → `rx_valid`=0 on the next edge.
- **Glitch rejection**: `rx` low for 3 ticks, then high → `busy` pulses, returns to IDLE, `rx_valid` stays 0.
- **Even parity**: `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07 with parity bit 1 → `parity_err`=0. Same frame with parity bit 0 → `parity_err`=1 and `rx_data`=0x07.
- **Framing and stop bits**: `STOP_BITS`=2, send 0x3C with the second stop bit low → `frame_err`=1, `rx_data`=0x3C.
- **Overrun and simultaneous ack**:
  - Two back-to-back frames 0x11, 0x22 with no ack → `rx_data`=0x11, `overrun_err`=1.
  - Repeat with `rx_ack` pulsed on the completion cycle of 0x22 → `rx_data`=0x22, `rx_valid`=1, `overrun_err`=0.
- **Reset mid-frame and 9-bit word**: assert `reset` during data bit 4 → all outputs 0; the next frame is received correctly. With `DATA_BITS`=9, send 0x1AB → `rx_data`=0x1AB.
